// File: rtl/present_encrypt_core.sv
// present_encrypt_core: iterative PRESENT-80/128 block encryption, one round per clock.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_data/in_key take a
//        plaintext+key; out_valid/out_ready/out_data return the ciphertext; busy while rounds run.
module present_encrypt_core #(
    parameter int KEY_WIDTH = 80,
    parameter int ROUNDS    = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_data,
    input  logic [KEY_WIDTH-1:0] in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data,
    output logic                 busy
);

    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key
        $error("present_encrypt_core: KEY_WIDTH must be 80 or 128");
    end

    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_encrypt_core: ROUNDS must be in 1..31");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_e;

    localparam logic [4:0] LAST_RC = 5'(ROUNDS);

    fsm_e                 fsm_q, fsm_d;
    logic [63:0]          st_q, st_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [4:0]           rc_q, rc_d;
    logic [63:0]          out_q, out_d;

    logic [63:0]          round_out;
    logic [KEY_WIDTH-1:0] key_next;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 stays put.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[(16*i) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

    assign round_out = p_layer(s_layer(st_q ^ key_q[KEY_WIDTH-1 -: 64]));

    // Key register update: rotate left by 61, S-box the top nibble(s),
    // fold the round counter into a fixed 5-bit window.
    if (KEY_WIDTH == 128) begin : g_k128
        logic [127:0] rot;
        always_comb begin
            rot = {key_q[66:0], key_q[127:67]};
            key_next = rot;
            key_next[127:124] = sbox(rot[127:124]);
            key_next[123:120] = sbox(rot[123:120]);
            key_next[66:62] = rot[66:62] ^ rc_q;
        end
    end else begin : g_k80
        logic [79:0] rot;
        always_comb begin
            rot = {key_q[18:0], key_q[79:19]};
            key_next = rot;
            key_next[79:76] = sbox(rot[79:76]);
            key_next[19:15] = rot[19:15] ^ rc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            key_q <= '0;
            rc_q  <= '0;
            out_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            key_q <= key_d;
            rc_q  <= rc_d;
            out_q <= out_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        key_d = key_q;
        rc_d  = rc_q;
        out_d = out_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    st_d  = in_data;
                    key_d = in_key;
                    rc_d  = 5'd1;
                    fsm_d = BUSY;
                end
            end
            BUSY: begin
                st_d  = round_out;
                key_d = key_next;
                // Final round also applies the whitening key.
                if (rc_q == LAST_RC) begin
                    out_d = round_out ^ key_next[KEY_WIDTH-1 -: 64];
                    fsm_d = DONE;
                end else begin
                    rc_d = rc_q + 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q == BUSY);
    assign out_valid = (fsm_q == DONE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_present_encrypt_core.sv
// tb_present_encrypt_core: randomized and known-answer bench for present_encrypt_core.
// Drives an 80-bit and a 128-bit instance, checking against a behavioural model.
module tb_present_encrypt_core;

    localparam int ROUNDS = 31;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sel = 1'b0;
    logic         iv = 1'b0;
    logic         ordy = 1'b0;
    logic [63:0]  idata = '0;
    logic [127:0] ikey = '0;

    logic         ir80, ov80, b80, ir128, ov128, b128;
    logic [63:0]  od80, od128;
    logic         ir, ov, bsy;
    logic [63:0]  od;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    present_encrypt_core #(.KEY_WIDTH(80), .ROUNDS(ROUNDS)) u_dut80 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv & ~sel),
        .in_ready  (ir80),
        .in_data   (idata),
        .in_key    (ikey[79:0]),
        .out_valid (ov80),
        .out_ready (ordy & ~sel),
        .out_data  (od80),
        .busy      (b80)
    );

    present_encrypt_core #(.KEY_WIDTH(128), .ROUNDS(ROUNDS)) u_dut128 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv & sel),
        .in_ready  (ir128),
        .in_data   (idata),
        .in_key    (ikey),
        .out_valid (ov128),
        .out_ready (ordy & sel),
        .out_data  (od128),
        .busy      (b128)
    );

    assign ir  = sel ? ir128 : ir80;
    assign ov  = sel ? ov128 : ov80;
    assign bsy = sel ? b128 : b80;
    assign od  = sel ? od128 : od80;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Straight-line PRESENT: 31 rounds of key-add, S-box, permutation,
    // then whitening with the 32nd round key.
    function automatic logic [63:0] present_ref(input logic [63:0] pt,
                                                input logic [127:0] key,
                                                input int kw);
        logic [127:0] mask;
        logic [127:0] k;
        logic [63:0]  s;
        logic [63:0]  t;
        mask = (kw == 128) ? '1 : ((128'd1 << 80) - 128'd1);
        k = key & mask;
        s = pt;
        for (int r = 1; r <= ROUNDS; r++) begin
            s = s ^ 64'(k >> (kw - 64));
            for (int n = 0; n < 16; n++) t[4*n +: 4] = SBOX[s[4*n +: 4]];
            s = '0;
            for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16*i) % 63] = t[i];
            k = ((k << 61) | (k >> (kw - 61))) & mask;
            k[kw-1 -: 4] = SBOX[k[kw-1 -: 4]];
            if (kw == 128) k[kw-5 -: 4] = SBOX[k[kw-5 -: 4]];
            k = k ^ (128'(r) << ((kw == 128) ? 62 : 15));
        end
        return s ^ 64'(k >> (kw - 64));
    endfunction

    task automatic encrypt(input logic w, input logic [63:0] pt,
                           input logic [127:0] k, output logic [63:0] ct);
        int n;
        int t0;
        sel = w;
        idata = pt;
        ikey = k;
        iv = 1'b1;
        ordy = 1'b0;
        #1;
        n = 0;
        while (!ir && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        t0 = cyc;
        iv = 1'b0;
        check("busy", {63'd0, bsy}, 64'd1);
        n = 0;
        while (!ov && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("out_valid", {63'd0, ov}, 64'd1);
        check("latency", 64'(cyc - t0), 64'(ROUNDS));
        ct = od;
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        check("ov_drop", {63'd0, ov}, 64'd0);
    endtask

    initial begin
        logic [63:0]  ct;
        logic [63:0]  exp;
        logic [63:0]  p;
        logic [127:0] k;
        logic [63:0]  pts [3];
        logic [127:0] keys [3];
        int           tv [3];
        int           n;
        logic         w;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ov", {63'd0, ov80}, 64'd0);
        check("rst_busy", {63'd0, b80}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", {63'd0, ir80}, 64'd1);
        check("rst_data", od80, 64'd0);
        check("rst_ready128", {63'd0, ir128}, 64'd1);

        encrypt(1'b0, 64'h0, 128'h0, ct);
        check("kat80_0_0", ct, 64'h5579C1387B228445);
        encrypt(1'b0, 64'h0, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, ct);
        check("kat80_0_1", ct, 64'hE72C46C0F5945049);
        encrypt(1'b0, 64'hFFFFFFFFFFFFFFFF, 128'h0, ct);
        check("kat80_1_0", ct, 64'hA112FFC72F68417B);
        encrypt(1'b0, 64'hFFFFFFFFFFFFFFFF, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, ct);
        check("kat80_1_1", ct, 64'h3333DCD3213210D2);
        encrypt(1'b1, 64'h0, 128'h0, ct);
        check("kat128_0_0", ct, 64'h96DB702A2E6900AF);

        for (int i = 0; i < 16; i++) begin
            w = 1'($urandom_range(0, 1));
            p = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            if (!w) k[127:80] = '0;
            encrypt(w, p, k, ct);
            check(w ? "rand128" : "rand80", ct, present_ref(p, k, w ? 128 : 80));
        end

        // Backpressure, with junk offered during BUSY and DONE.
        p = {$urandom, $urandom};
        k = {48'h0, 16'($urandom), $urandom, $urandom};
        exp = present_ref(p, k, 80);
        sel = 1'b0;
        idata = p;
        ikey = k;
        iv = 1'b1;
        ordy = 1'b0;
        #1;
        n = 0;
        while (!ir && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        idata = ~p;
        ikey = ~k;
        repeat (3) @(posedge clk);
        #1;
        iv = 1'b0;
        n = 0;
        while (!ov && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_valid", {63'd0, ov}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            iv = (i >= 3 && i < 6);
            check("bp_data", od, exp);
            check("bp_ready", {63'd0, ir}, 64'd0);
            @(posedge clk);
            #1;
        end
        iv = 1'b0;
        check("bp_hold", {63'd0, ov}, 64'd1);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        check("bp_ack", {63'd0, ov}, 64'd0);

        // Reset in the middle of a block.
        idata = 64'h0123456789ABCDEF;
        ikey = 128'h0;
        iv = 1'b1;
        #1;
        n = 0;
        while (!ir && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        iv = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        check("mid_busy", {63'd0, bsy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_ov", {63'd0, ov}, 64'd0);
        check("mid_busy0", {63'd0, bsy}, 64'd0);
        check("mid_data", od, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        encrypt(1'b0, 64'h0, 128'h0, ct);
        check("mid_kat", ct, 64'h5579C1387B228445);

        // Back-to-back with in_valid and out_ready held high.
        for (int b = 0; b < 3; b++) begin
            pts[b] = {$urandom, $urandom};
            keys[b] = {48'h0, 16'($urandom), $urandom, $urandom};
        end
        sel = 1'b0;
        idata = pts[0];
        ikey = keys[0];
        iv = 1'b1;
        ordy = 1'b1;
        for (int b = 0; b < 3; b++) begin
            n = 0;
            #1;
            while (!ov && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            tv[b] = cyc;
            check("b2b_valid", {63'd0, ov}, 64'd1);
            check("b2b_data", od, present_ref(pts[b], keys[b], 80));
            if (b < 2) begin
                idata = pts[b+1];
                ikey = keys[b+1];
            end
            if (b > 0) check("b2b_gap", 64'(tv[b] - tv[b-1]), 64'(ROUNDS + 2));
            @(posedge clk);
        end
        iv = 1'b0;
        ordy = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
